// File: rtl/fifo_param.sv
// ============================================================================
// Module   : fifo_param
// Brief    : Parametrised single-clock FIFO. It has an occupancy count, BIG and
//            SMALL threshold flags and a registered read port (1-cycle latency).
//            Define FIFO_ERR_EN to build the sticky OVERFLOW/UNDERFLOW flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           DATA_IN,
    input  logic                       WRITE,
    input  logic                       READ,
    output logic [WIDTH-1:0]           DATA_OUT,
    output logic                       Valid,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       BIG,
    output logic                       SMALL,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = $clog2(DEPTH);

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF_CNT    = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE_CNT    = c_CW'(AE_LEVEL);
    localparam logic [c_PW-1:0] c_PTR_LAST  = c_PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [c_PW-1:0] f_ptr_next(input logic [c_PW-1:0] i_ptr);
        return (i_ptr == c_PTR_LAST) ? '0 : i_ptr + 1'b1;
    endfunction

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // A write when full is accepted only if a read frees a slot on the same
    // edge. A read when empty never bypasses a simultaneous write.
    assign w_wr_ok = WRITE && (!w_full || READ);
    assign w_rd_ok = READ && !w_empty;

    always_ff @(posedge CLK) begin
        if (w_wr_ok && !RESET) begin
            r_mem[r_wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= f_ptr_next(r_wr_ptr);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (WRITE && w_full && !READ) begin
                r_overflow <= 1'b1;
            end
            if (READ && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

    assign DATA_OUT = r_data_out;
    assign Valid    = r_valid;
    assign COUNT    = r_count;
    assign FULL     = w_full;
    assign EMPTY    = w_empty;
    assign BIG      = (r_count >= c_AF_CNT);
    assign SMALL    = (r_count <= c_AE_CNT);

endmodule

`default_nettype wire
